id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  input  1  rising-edge system clock; one clock domain.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 in_valid  input  1  decode offers an instruction this cycle.
REQ-004 in_ready  output  1  stage can accept; in_ready = NOT skid_valid (combinational from state only).
REQ-005 in_In1, in_In2  input  32 each  ALU operands, already source-muxed.
REQ-006 in_ALU_Op  input  2; in_funct3  input  3; in_funct7  input  7  ALU control fields.
REQ-007 in_rd  input  5; in_PC  input  32  destination register, instruction address.
REQ-008 in_RegWrite, in_MemRead, in_MemWrite, in_MemtoReg, in_Branch  input  1 each  control bits.
REQ-009 flush  input  1  synchronous kill of all held entries (branch taken / trap).
REQ-010 out_valid  output  1  out_* fields hold a live instruction for ALU / ALU_Control_Unit.
REQ-011 out_ready  input  1  execute consumes the output entry this cycle.
REQ-012 out_* outputs mirroring every in_* payload field with identical widths.
REQ-013 bubble_count  output  16  execute-idle cycle counter (see Configuration).

Function
REQ-014 Storage: two entries, main (drives out_*) and skid; each with a valid bit; strict FIFO order.
REQ-015 Accept = in_valid AND in_ready; transfer = out_valid AND out_ready; out_valid = main_valid.
REQ-016 Latency: an accepted instruction appears on out_* the cycle after acceptance if main empty or main transferring.
REQ-017 Accept, main empty: payload to main, main_valid=1 next cycle.
REQ-018 Accept, main full, no transfer: payload to skid, skid_valid=1, in_ready=0 next cycle.
REQ-019 Accept and transfer same cycle, skid empty: new payload overwrites main, main_valid stays 1.
REQ-020 Transfer, skid full: skid to main, skid_valid=0, in_ready=1 next cycle; in_ready is 0 that cycle so no accept.
REQ-021 Transfer, skid empty, no accept: main_valid=0 next cycle.
REQ-022 No transfer: main payload held stable bit-for-bit while out_valid=1.
REQ-023 flush has priority: both valid bits cleared next cycle; input offered in the flush cycle is dropped; output transfer in that cycle still counts as consumed.
REQ-024 When out_valid=0, out_RegWrite, out_MemRead, out_MemWrite, out_Branch, out_MemtoReg forced 0 (bubble); data fields unconstrained.
REQ-025 No combinational path from in_valid, in_* or out_ready to in_ready or out_*.

Reset
REQ-026 rst_n low: immediately main_valid=0, skid_valid=0, all stored payload=0, bubble_count=0.
REQ-027 While in reset and first cycle after: out_valid=0, in_ready=1, all out_* = 0.
REQ-028 Reset asserted mid-transfer discards both entries; no partial instruction is presented after release.

Configuration
REQ-029 Macro ID_EX_BUBBLE_CNT_EN defined: bubble_count increments by 1 on each rising edge with out_valid=0, saturates at 16'hFFFF, cleared only by reset.
REQ-030 Macro undefined: bubble_count port present, tied to 16'h0000, no counter flops.

Verification
REQ-031 Reset then in_valid=1, In1=1, In2=2, ALU_Op=0 -> out_valid=1 next cycle, out_In1=1, out_In2=2; ALU_Result=3.
REQ-032 out_ready=0, push A(In1=10) and B(In1=12) -> in_ready=0 after B; out_In1=10 held; out_ready=1 -> 10 then 12 in order, in_ready=1 again.
REQ-033 Continuous in_valid=1, out_ready=1, 8 instructions -> one output per cycle, in_ready never 0.
REQ-034 Both entries full with RegWrite=1, flush=1 -> next cycle out_valid=0, out_RegWrite=0, in_ready=1; input in flush cycle absent from output.
REQ-035 rst_n pulsed low asynchronously between edges with main full -> out_valid=0 immediately, out_In1=0.
REQ-036 ID_EX_BUBBLE_CNT_EN defined, 5 idle cycles after reset -> bubble_count=5; held 70000 idle cycles -> 16'hFFFF; undefined -> always 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: two-entry (main + skid) elastic buffer between decode and execute.
// Optional execute-idle counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_In1,
    input  logic [31:0] in_In2,
    input  logic [1:0]  in_ALU_Op,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_PC,
    input  logic        in_RegWrite,
    input  logic        in_MemRead,
    input  logic        in_MemWrite,
    input  logic        in_MemtoReg,
    input  logic        in_Branch,

    input  logic        flush,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_In1,
    output logic [31:0] out_In2,
    output logic [1:0]  out_ALU_Op,
    output logic [2:0]  out_funct3,
    output logic [6:0]  out_funct7,
    output logic [4:0]  out_rd,
    output logic [31:0] out_PC,
    output logic        out_RegWrite,
    output logic        out_MemRead,
    output logic        out_MemWrite,
    output logic        out_MemtoReg,
    output logic        out_Branch,

    output logic [15:0] bubble_count
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned F3_W     = 3;
    localparam int unsigned F7_W     = 7;
    localparam int unsigned RD_W     = 5;
    localparam int unsigned BUBBLE_W = 16;

    typedef struct packed {
        logic [DATA_W-1:0]  in1;
        logic [DATA_W-1:0]  in2;
        logic [ALUOP_W-1:0] alu_op;
        logic [F3_W-1:0]    funct3;
        logic [F7_W-1:0]    funct7;
        logic [RD_W-1:0]    rd;
        logic [DATA_W-1:0]  pc;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               branch;
    } payload_t;

    payload_t main_q, main_d;
    payload_t skid_q, skid_d;
    payload_t in_payload;
    logic     main_valid_q, main_valid_d;
    logic     skid_valid_q, skid_valid_d;
    logic     in_ready_q, in_ready_d;
    logic     accept;
    logic     xfer;

    // Strip side-effecting control bits so an empty main entry presents a bubble.
    function automatic payload_t kill_ctrl(input payload_t p);
        payload_t r;
        r            = p;
        r.reg_write  = 1'b0;
        r.mem_read   = 1'b0;
        r.mem_write  = 1'b0;
        r.mem_to_reg = 1'b0;
        r.branch     = 1'b0;
        return r;
    endfunction

    always_comb begin
        in_payload.in1        = in_In1;
        in_payload.in2        = in_In2;
        in_payload.alu_op     = in_ALU_Op;
        in_payload.funct3     = in_funct3;
        in_payload.funct7     = in_funct7;
        in_payload.rd         = in_rd;
        in_payload.pc         = in_PC;
        in_payload.reg_write  = in_RegWrite;
        in_payload.mem_read   = in_MemRead;
        in_payload.mem_write  = in_MemWrite;
        in_payload.mem_to_reg = in_MemtoReg;
        in_payload.branch     = in_Branch;
    end

    assign accept = in_valid & in_ready_q;
    assign xfer   = main_valid_q & out_ready;

    // Next-state for the two entries; skid is only ever filled while main holds and stalls.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (accept) begin
                main_d       = in_payload;
                main_valid_d = 1'b1;
            end
        end else if (xfer) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = in_payload;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_payload;
            skid_valid_d = 1'b1;
        end

        if (!main_valid_d) begin
            main_d = kill_ctrl(main_d);
        end
        if (!skid_valid_d) begin
            skid_d = kill_ctrl(skid_d);
        end

        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = main_valid_q;
    assign out_In1      = main_q.in1;
    assign out_In2      = main_q.in2;
    assign out_ALU_Op   = main_q.alu_op;
    assign out_funct3   = main_q.funct3;
    assign out_funct7   = main_q.funct7;
    assign out_rd       = main_q.rd;
    assign out_PC       = main_q.pc;
    assign out_RegWrite = main_q.reg_write;
    assign out_MemRead  = main_q.mem_read;
    assign out_MemWrite = main_q.mem_write;
    assign out_MemtoReg = main_q.mem_to_reg;
    assign out_Branch   = main_q.branch;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [BUBBLE_W-1:0] bubble_q, bubble_d;

    // Saturating count of edges on which execute had nothing to consume.
    always_comb begin
        bubble_d = bubble_q;
        if (!main_valid_q && (bubble_q != {BUBBLE_W{1'b1}})) begin
            bubble_d = bubble_q + BUBBLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_q <= '0;
        end else begin
            bubble_q <= bubble_d;
        end
    end

    assign bubble_count = bubble_q;
`else
    assign bubble_count = BUBBLE_W'(0);
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for id_ex_stage: handshake ordering, skid, flush, reset and bubble counter.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_In1, in_In2, in_PC;
    logic [1:0]  in_ALU_Op;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic        in_RegWrite, in_MemRead, in_MemWrite, in_MemtoReg, in_Branch;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_In1, out_In2, out_PC;
    logic [1:0]  out_ALU_Op;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [4:0]  out_rd;
    logic        out_RegWrite, out_MemRead, out_MemWrite, out_MemtoReg, out_Branch;
    logic [15:0] bubble_count;

    int tests = 0;
    int fails = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_In1(in_In1), .in_In2(in_In2), .in_ALU_Op(in_ALU_Op),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd), .in_PC(in_PC),
        .in_RegWrite(in_RegWrite), .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite),
        .in_MemtoReg(in_MemtoReg), .in_Branch(in_Branch),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_In1(out_In1), .out_In2(out_In2), .out_ALU_Op(out_ALU_Op),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_rd(out_rd), .out_PC(out_PC),
        .out_RegWrite(out_RegWrite), .out_MemRead(out_MemRead), .out_MemWrite(out_MemWrite),
        .out_MemtoReg(out_MemtoReg), .out_Branch(out_Branch),
        .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] in1;
        logic        ordy;
        logic        fl;
        logic        exp_ov;
        logic        exp_ir;
        logic [31:0] exp_in1;
    } vec_t;

    // Every payload field is derived from In1 so one number identifies a whole instruction.
    function automatic logic [117:0] mk_payload(input logic [31:0] v);
        logic [31:0] in2, pc;
        logic [4:0]  rd;
        in2 = v ^ 32'h0000_0003;
        pc  = (v << 2) ^ 32'h0000_1000;
        rd  = v[4:0] + 5'd1;
        return {v, in2, v[9:8], v[7:5], v[14:8], rd, pc, v[4], v[0], v[1], v[2], v[3]};
    endfunction

    function automatic logic [117:0] dut_out();
        return {out_In1, out_In2, out_ALU_Op, out_funct3, out_funct7, out_rd, out_PC,
                out_RegWrite, out_MemRead, out_MemWrite, out_MemtoReg, out_Branch};
    endfunction

    task automatic drive(input logic iv, input logic [31:0] v, input logic ordy, input logic fl);
        logic [117:0] p;
        p = mk_payload(v);
        in_valid = iv;
        {in_In1, in_In2, in_ALU_Op, in_funct3, in_funct7, in_rd, in_PC,
         in_RegWrite, in_MemRead, in_MemWrite, in_MemtoReg, in_Branch} = p;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input logic ov, input logic ir, input logic [31:0] e1);
        logic [117:0] exp_p;
        exp_p = mk_payload(e1);
        cmp({name, ".out_valid"}, 128'(out_valid), 128'(ov));
        cmp({name, ".in_ready"}, 128'(in_ready), 128'(ir));
        if (ov) begin
            cmp({name, ".payload"}, 128'(dut_out()), 128'(exp_p));
        end else begin
            cmp({name, ".bubble_ctrl"},
                128'({out_RegWrite, out_MemRead, out_MemWrite, out_MemtoReg, out_Branch}), 128'(0));
        end
    endtask

    task automatic check_all_zero(input string name);
        cmp({name, ".out_valid"}, 128'(out_valid), 128'(0));
        cmp({name, ".in_ready"}, 128'(in_ready), 128'(1));
        cmp({name, ".outs"}, 128'(dut_out()), 128'(0));
        cmp({name, ".bubble"}, 128'(bubble_count), 128'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #12;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs[$];

    task automatic add(input logic iv, input logic [31:0] in1, input logic ordy, input logic fl,
                       input logic ov, input logic ir, input logic [31:0] e1);
        vec_t v;
        v = '{iv, in1, ordy, fl, ov, ir, e1};
        vecs.push_back(v);
    endtask

    initial begin
        // Basic: In1=1, In2=2, ALU_Op=0 appears next cycle, then drains.
        add(1, 32'd1,  0, 0, 1, 1, 32'd1);
        add(0, 32'd0,  1, 0, 0, 1, 32'd0);
        // Stall: A then B fills skid, C refused, drain in order.
        add(1, 32'd10, 0, 0, 1, 1, 32'd10);
        add(1, 32'd12, 0, 0, 1, 0, 32'd10);
        add(1, 32'd99, 0, 0, 1, 0, 32'd10);
        add(1, 32'd99, 1, 0, 1, 1, 32'd12);
        add(0, 32'd0,  1, 0, 0, 1, 32'd0);
        // Streaming: one per cycle, in_ready stays high.
        for (int i = 0; i < 8; i++) add(1, 32'(20 + i), 1, 0, 1, 1, 32'(20 + i));
        add(0, 32'd0,  1, 0, 0, 1, 32'd0);
        // Flush with both entries full (RegWrite set), then flush dropping an acceptable input.
        add(1, 32'd48, 0, 0, 1, 1, 32'd48);
        add(1, 32'd49, 0, 0, 1, 0, 32'd48);
        add(1, 32'd50, 0, 1, 0, 1, 32'd0);
        add(1, 32'd51, 0, 1, 0, 1, 32'd0);
        add(0, 32'd0,  0, 0, 0, 1, 32'd0);
        add(1, 32'd52, 0, 0, 1, 1, 32'd52);
        add(1, 32'd53, 1, 1, 0, 1, 32'd0);
        add(0, 32'd0,  1, 0, 0, 1, 32'd0);
        // Transfer and accept with skid empty overwrites main.
        add(1, 32'd60, 0, 0, 1, 1, 32'd60);
        add(1, 32'd61, 1, 0, 1, 1, 32'd61);
        add(0, 32'd0,  0, 0, 1, 1, 32'd61);
        add(0, 32'd0,  1, 0, 0, 1, 32'd0);

        do_reset();
        check_all_zero("reset_release");
        repeat (5) @(posedge clk);
        #1;
`ifdef ID_EX_BUBBLE_CNT_EN
        cmp("bubble_5", 128'(bubble_count), 128'(5));
`else
        cmp("bubble_5", 128'(bubble_count), 128'(0));
`endif
        cmp("idle_out_valid", 128'(out_valid), 128'(0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].iv, vecs[i].in1, vecs[i].ordy, vecs[i].fl);
            @(posedge clk);
            #1;
            check_state($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_ir, vecs[i].exp_in1);
        end

        // Asynchronous reset between edges with main full.
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check_state("pre_async", 1'b1, 1'b1, 32'h55);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cmp("post_rst.out_valid", 128'(out_valid), 128'(0));
        cmp("post_rst.outs", 128'(dut_out()), 128'(0));

        // Saturation of the idle counter.
        do_reset();
        repeat (70000) @(posedge clk);
        #1;
`ifdef ID_EX_BUBBLE_CNT_EN
        cmp("bubble_sat", 128'(bubble_count), 128'(16'hFFFF));
`else
        cmp("bubble_sat", 128'(bubble_count), 128'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
